// File: rtl/rsa_cmd_master_if.sv
// Command/data/done bus between the host-side RSA initiator and the RSA FPGA wrapper.
// Signal names match the wrapper's arm_to_fpga_* / fpga_to_arm_* ports one-for-one.
interface rsa_cmd_master_if;

  logic [31:0]   arm_to_fpga_cmd;
  logic          arm_to_fpga_cmd_valid;
  logic [1023:0] arm_to_fpga_data;
  logic          arm_to_fpga_data_valid;
  logic          arm_to_fpga_data_ready;
  logic [1023:0] fpga_to_arm_data;
  logic          fpga_to_arm_data_valid;
  logic          fpga_to_arm_data_ready;
  logic          fpga_to_arm_done;
  logic          fpga_to_arm_done_read;

  modport master (
    output arm_to_fpga_cmd,
    output arm_to_fpga_cmd_valid,
    output arm_to_fpga_data,
    output arm_to_fpga_data_valid,
    input  arm_to_fpga_data_ready,
    input  fpga_to_arm_data,
    input  fpga_to_arm_data_valid,
    output fpga_to_arm_data_ready,
    input  fpga_to_arm_done,
    output fpga_to_arm_done_read
  );

  modport slave (
    input  arm_to_fpga_cmd,
    input  arm_to_fpga_cmd_valid,
    input  arm_to_fpga_data,
    input  arm_to_fpga_data_valid,
    output arm_to_fpga_data_ready,
    output fpga_to_arm_data,
    output fpga_to_arm_data_valid,
    input  fpga_to_arm_data_ready,
    output fpga_to_arm_done,
    input  fpga_to_arm_done_read
  );

endinterface

// File: rtl/rsa_cmd_master.sv
// rsa_cmd_master: sequences one RSA exponentiation job (6x LOAD, COMPUTE, READBACK) on the wrapper bus.
// Define RSA_MASTER_TIMEOUT_EN to bound every wait by TIMEOUT_CYCLES; otherwise err stays 0.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | job_ready high, waiting for a job
// S_CMD       | one-cycle command pulse for the current phase
// S_DATA_OUT  | waiting for slave data_ready, then one-cycle operand pulse
// S_DATA_IN   | waiting for slave result word, then one-cycle ready pulse
// S_WAIT_DONE | waiting for slave done
// S_ACK       | one-cycle done_read pulse
// S_DRAIN     | waiting for the registered done to fall, then advance phase
// S_RESULT    | holding res_valid/res_data until res_ready
module rsa_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            job_valid,
  output logic            job_ready,
  input  logic [1023:0]   job_msg,
  input  logic [1023:0]   job_exp,
  input  logic [1023:0]   job_n,
  input  logic [1023:0]   job_rmodn,
  input  logic [1023:0]   job_r2modn,

  output logic            res_valid,
  input  logic            res_ready,
  output logic [1023:0]   res_data,

  output logic            busy,
  output logic            err,

  rsa_cmd_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA_OUT,
    S_DATA_IN,
    S_WAIT_DONE,
    S_ACK,
    S_DRAIN,
    S_RESULT
  } state_t;

  typedef enum logic [2:0] {
    PH_LOAD0,
    PH_LOAD1,
    PH_LOAD2,
    PH_LOAD3,
    PH_LOAD4,
    PH_LOAD5,
    PH_COMPUTE,
    PH_READBACK
  } phase_t;

  localparam logic [31:0] CMD_LOAD     = 32'd0;
  localparam logic [31:0] CMD_COMPUTE  = 32'd1;
  localparam logic [31:0] CMD_READBACK = 32'd2;
  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;

  logic [1023:0] msg_q, exp_q, n_q, rmodn_q, r2modn_q;
  logic [1023:0] load_word;

  logic          job_ready_q;
  logic          res_valid_q;
  logic [1023:0] res_q, res_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [31:0]   cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [1023:0] wdata_q, wdata_d;
  logic          wvalid_q, wvalid_d;
  logic          rready_q, rready_d;
  logic          done_read_q, done_read_d;

  logic          job_accept;
  logic          tmo_hit;

  function automatic logic [31:0] cmd_code(input phase_t ph);
    case (ph)
      PH_COMPUTE:  cmd_code = CMD_COMPUTE;
      PH_READBACK: cmd_code = CMD_READBACK;
      default:     cmd_code = CMD_LOAD;
    endcase
  endfunction

  function automatic logic is_wait(input state_t s);
    is_wait = (s == S_DATA_OUT) || (s == S_DATA_IN) ||
              (s == S_WAIT_DONE) || (s == S_DRAIN);
  endfunction

  assign job_accept = (state_q == S_IDLE) && job_ready_q && job_valid;

  // LOAD5 sends a zero pad so the slave's six-slot parameter counter wraps every job.
  always_comb begin
    load_word = '0;
    case (phase_q)
      PH_LOAD0: load_word = msg_q;
      PH_LOAD1: load_word = exp_q;
      PH_LOAD2: load_word = n_q;
      PH_LOAD3: load_word = rmodn_q;
      PH_LOAD4: load_word = r2modn_q;
      default:  load_word = '0;
    endcase
  end

`ifdef RSA_MASTER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  assign tmo_hit = is_wait(state_q) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (is_wait(state_d) && (state_d != state_q)) begin
      tmo_cnt_q <= '0;
    end else if (is_wait(state_q)) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_LAST;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    busy_d      = busy_q;
    err_d       = err_q;
    res_d       = res_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    wdata_d     = wdata_q;
    wvalid_d    = 1'b0;
    rready_d    = 1'b0;
    done_read_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (job_accept) begin
          state_d = S_CMD;
          phase_d = PH_LOAD0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_CMD: begin
        case (phase_q)
          PH_COMPUTE:  state_d = S_WAIT_DONE;
          PH_READBACK: state_d = S_DATA_IN;
          default:     state_d = S_DATA_OUT;
        endcase
      end
      S_DATA_OUT: begin
        if (bus.arm_to_fpga_data_ready) begin
          wvalid_d = 1'b1;
          wdata_d  = load_word;
          state_d  = S_WAIT_DONE;
        end
      end
      S_DATA_IN: begin
        if (bus.fpga_to_arm_data_valid) begin
          rready_d = 1'b1;
          res_d    = bus.fpga_to_arm_data;
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.fpga_to_arm_done) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The slave's done lags done_read by a cycle or more; never count it twice.
        if (!bus.fpga_to_arm_done) begin
          if (phase_q == PH_READBACK) begin
            state_d = S_RESULT;
          end else begin
            phase_d = phase_t'(phase_q + 3'd1);
            state_d = S_CMD;
          end
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A wait that completes on its last allowed cycle still counts as completed.
    if (tmo_hit && (state_d == state_q)) begin
      state_d     = S_IDLE;
      err_d       = 1'b1;
      busy_d      = 1'b0;
      done_read_d = 1'b1;
    end

    if (state_d == S_CMD) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_code(phase_d);
    end

    if (state_d == S_ACK) begin
      done_read_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_LOAD0;
      job_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      done_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      job_ready_q <= (state_d == S_IDLE);
      res_valid_q <= (state_d == S_RESULT);
      res_q       <= res_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      done_read_q <= done_read_d;
    end
  end

  // Operands survive reset; they are only ever replaced by a new accepted job.
  always_ff @(posedge clk) begin
    if (resetn && job_accept) begin
      msg_q    <= job_msg;
      exp_q    <= job_exp;
      n_q      <= job_n;
      rmodn_q  <= job_rmodn;
      r2modn_q <= job_r2modn;
    end
  end

  assign job_ready = job_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign busy      = busy_q;
  assign err       = err_q;

  assign bus.arm_to_fpga_cmd        = cmd_q;
  assign bus.arm_to_fpga_cmd_valid  = cmd_valid_q;
  assign bus.arm_to_fpga_data       = wdata_q;
  assign bus.arm_to_fpga_data_valid = wvalid_q;
  assign bus.fpga_to_arm_data_ready = rready_q;
  assign bus.fpga_to_arm_done_read  = done_read_q;

endmodule

// File: tb/tb_rsa_cmd_master.sv
// Bench for rsa_cmd_master: behavioural RSA slave on the bus, job-level expectations from modexp arithmetic.
module tb_rsa_cmd_master;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1023:0] job_msg = '0, job_exp = '0, job_n = '0, job_rmodn = '0, job_r2modn = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [1023:0] res_data;
  logic          busy, err;

  always #5 clk = ~clk;

  rsa_cmd_master_if bus ();

  rsa_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_msg    (job_msg),
    .job_exp    (job_exp),
    .job_n      (job_n),
    .job_rmodn  (job_rmodn),
    .job_r2modn (job_r2modn),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .err        (err),
    .bus        (bus)
  );

  int checks = 0;
  int failures = 0;

  // slave knobs (written by the main sequence only)
  int unsigned sl_min_delay = 0;
  int unsigned sl_max_delay = 2;
  int          sl_stale = 0;
  bit          sl_never_done = 1'b0;
  bit          sl_clear = 1'b0;

  // slave observations (written by the slave only)
  logic [31:0]   cmd_log [$];
  logic [1023:0] word_log [$];
  int            done_reads = 0;
  int            extra_done_reads = 0;
  int            viol = 0;

  logic [31:0]   exp_cmd [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2};

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    longint unsigned r, x, mm;
    if (m == 32'd0) return 32'd0;
    mm = longint'(m);
    r  = 64'd1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int pick_delay();
    return int'($urandom_range(sl_max_delay, sl_min_delay));
  endfunction

  // Behavioural slave: acts on the falling edge, so every input it drives is seen at the next rising edge.
  initial begin : slave
    int st, cnt, idx;
    logic [31:0] cur;
    logic [1023:0] slot [6];
    logic [1023:0] result;
    logic pcv, pdv, prr, pdr;
    st = 0; cnt = 0; idx = 0; cur = '0; result = '0;
    pcv = 0; pdv = 0; prr = 0; pdr = 0;
    for (int i = 0; i < 6; i++) slot[i] = '0;
    bus.arm_to_fpga_data_ready = 1'b0;
    bus.fpga_to_arm_data       = '0;
    bus.fpga_to_arm_data_valid = 1'b0;
    bus.fpga_to_arm_done       = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn || sl_clear) begin
        st = 0; cnt = 0; idx = 0;
        pcv = 0; pdv = 0; prr = 0; pdr = 0;
        bus.arm_to_fpga_data_ready = 1'b0;
        bus.fpga_to_arm_data_valid = 1'b0;
        bus.fpga_to_arm_done       = 1'b0;
      end else begin
        if (bus.arm_to_fpga_cmd_valid && pcv) viol++;
        if (bus.arm_to_fpga_data_valid && pdv) viol++;
        if (bus.fpga_to_arm_data_ready && prr) viol++;
        if (bus.fpga_to_arm_done_read && pdr) viol++;
        if (bus.arm_to_fpga_cmd_valid && bus.fpga_to_arm_done) viol++;
        pcv = bus.arm_to_fpga_cmd_valid;
        pdv = bus.arm_to_fpga_data_valid;
        prr = bus.fpga_to_arm_data_ready;
        pdr = bus.fpga_to_arm_done_read;
        if (bus.fpga_to_arm_done_read && st != 4) extra_done_reads++;
        if (bus.arm_to_fpga_cmd_valid) begin
          if (st != 0) viol++;
          cur = bus.arm_to_fpga_cmd;
          cmd_log.push_back(cur);
          cnt = pick_delay();
          if (cur == 32'd1) begin
            result = {992'd0, modexp(slot[0][31:0], slot[1][31:0], slot[2][31:0])};
            st = 2;
          end else if (cur == 32'd2) begin
            st = 3;
          end else begin
            st = 1;
          end
        end else begin
          case (st)
            1: begin
              if (bus.arm_to_fpga_data_valid) begin
                word_log.push_back(bus.arm_to_fpga_data);
                slot[idx] = bus.arm_to_fpga_data;
                idx = (idx + 1) % 6;
                bus.arm_to_fpga_data_ready = 1'b0;
                cnt = pick_delay();
                st = 2;
              end else if (cnt > 0) cnt--;
              else bus.arm_to_fpga_data_ready = 1'b1;
            end
            2: begin
              if (cur == 32'd1 && sl_never_done) cnt = cnt;
              else if (cnt > 0) cnt--;
              else begin bus.fpga_to_arm_done = 1'b1; st = 4; end
            end
            3: begin
              if (bus.fpga_to_arm_data_ready) begin
                bus.fpga_to_arm_data_valid = 1'b0;
                cnt = pick_delay();
                st = 2;
              end else if (cnt > 0) cnt--;
              else begin
                bus.fpga_to_arm_data       = result;
                bus.fpga_to_arm_data_valid = 1'b1;
              end
            end
            4: begin
              if (bus.fpga_to_arm_done_read) begin
                done_reads++;
                if (sl_stale == 0) begin bus.fpga_to_arm_done = 1'b0; st = 0; end
                else begin cnt = sl_stale; st = 5; end
              end
            end
            5: begin
              cnt--;
              if (cnt <= 0) begin bus.fpga_to_arm_done = 1'b0; st = 0; end
            end
            default: st = 0;
          endcase
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [1023:0] m, input logic [1023:0] e, input logic [1023:0] nn,
                           input logic [1023:0] rm, input logic [1023:0] r2,
                           output int cb, output int wb, output int db, output bit tmo);
    int cyc;
    cb = cmd_log.size(); wb = word_log.size(); db = done_reads; tmo = 1'b0;
    job_msg = m; job_exp = e; job_n = nn; job_rmodn = rm; job_r2modn = r2;
    job_valid = 1'b1;
    cyc = 0;
    while (!job_ready && cyc < 200) begin step(); cyc++; end
    if (!job_ready) tmo = 1'b1;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_result(output bit tmo);
    int cyc;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 3000) begin step(); cyc++; end
    tmo = (res_valid !== 1'b1);
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    checks++;
    if ({job_ready, res_valid, busy, err, bus.arm_to_fpga_cmd_valid, bus.arm_to_fpga_data_valid,
         bus.fpga_to_arm_data_ready, bus.fpga_to_arm_done_read} !== 8'b0) begin
      failures++;
      $display("FAIL reset_flags got %b want 00000000", {job_ready, res_valid, busy, err,
               bus.arm_to_fpga_cmd_valid, bus.arm_to_fpga_data_valid, bus.fpga_to_arm_data_ready,
               bus.fpga_to_arm_done_read});
    end
    checks++;
    if (bus.arm_to_fpga_cmd !== 32'd0 || bus.arm_to_fpga_data !== 1024'd0 || res_data !== 1024'd0) begin
      failures++;
      $display("FAIL reset_buses cmd=%0h data_lo=%0h res_lo=%0h want 0", bus.arm_to_fpga_cmd,
               bus.arm_to_fpga_data[31:0], res_data[31:0]);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release job_ready=%b busy=%b want 1 0", job_ready, busy);
    end
  endtask

  task automatic test_single_job(input string name, input logic [1023:0] m, input logic [1023:0] e,
                                 input logic [1023:0] nn, input logic [1023:0] rm, input logic [1023:0] r2);
    int cb, wb, db, ex0, v0;
    bit tmo;
    logic [1023:0] want_res;
    logic [1023:0] want_w [6];
    ex0 = extra_done_reads; v0 = viol;
    want_res = {992'd0, modexp(m[31:0], e[31:0], nn[31:0])};
    want_w = '{m, e, nn, rm, r2, 1024'd0};
    start_job(m, e, nn, rm, r2, cb, wb, db, tmo);
    checks++;
    if (tmo || busy !== 1'b1 || job_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept tmo=%b busy=%b job_ready=%b err=%b want 0 1 0 0", name, tmo, busy, job_ready, err);
    end
    wait_result(tmo);
    checks++;
    if (tmo || res_data !== want_res) begin
      failures++;
      $display("FAIL %s_result tmo=%b got %0h want %0h", name, tmo, res_data[63:0], want_res[63:0]);
    end
    accept_result();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle res_valid=%b busy=%b job_ready=%b want 0 0 1", name, res_valid, busy, job_ready);
    end
    checks++;
    if (cmd_log.size() - cb !== 8 || word_log.size() - wb !== 6) begin
      failures++;
      $display("FAIL %s_counts cmds=%0d words=%0d want 8 6", name, cmd_log.size() - cb, word_log.size() - wb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cmd_log[cb + i] !== exp_cmd[i]) begin
        failures++;
        $display("FAIL %s_cmd%0d got %0d want %0d", name, i, cmd_log[cb + i], exp_cmd[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (word_log[wb + i] !== want_w[i]) begin
        failures++;
        $display("FAIL %s_word%0d got %0h want %0h", name, i, word_log[wb + i][63:0], want_w[i][63:0]);
      end
    end
    checks++;
    if (done_reads - db !== 8 || extra_done_reads - ex0 !== 0 || viol - v0 !== 0) begin
      failures++;
      $display("FAIL %s_protocol done_reads=%0d extra=%0d violations=%0d want 8 0 0", name,
               done_reads - db, extra_done_reads - ex0, viol - v0);
    end
  endtask

  task automatic test_backpressure();
    int cb, wb, db;
    bit tmo;
    logic [1023:0] m, e, nn, want_res;
    int bad;
    m = rand1024(); e = rand1024(); nn = rand1024(); nn[0] = 1'b1;
    want_res = {992'd0, modexp(m[31:0], e[31:0], nn[31:0])};
    start_job(m, e, nn, rand1024(), rand1024(), cb, wb, db, tmo);
    wait_result(tmo);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tmo || res_valid !== 1'b1 || res_data !== want_res || job_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; bad++;
        if (bad < 3) $display("FAIL bp_hold%0d res_valid=%b res=%0h job_ready=%b want 1 %0h 0", i,
                               res_valid, res_data[63:0], job_ready, want_res[63:0]);
      end
      step();
    end
    accept_result();
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release res_valid=%b job_ready=%b busy=%b want 0 1 0", res_valid, job_ready, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    int cb, wb, db, n, cyc;
    bit tmo;
    sl_min_delay = 6; sl_max_delay = 6;
    start_job(rand1024(), rand1024(), rand1024(), rand1024(), rand1024(), cb, wb, db, tmo);
    n = 0; cyc = 0;
    while (cyc < 300) begin
      if (bus.arm_to_fpga_cmd_valid) n++;
      if (n == 3) break;
      step(); cyc++;
    end
    checks++;
    if (n != 3 || bus.arm_to_fpga_cmd !== 32'd0) begin
      failures++;
      $display("FAIL midload_reach cmds=%0d want 3", n);
    end
    step(); step();
    resetn = 1'b0;
    step();
    checks++;
    if ({job_ready, res_valid, busy, err, bus.arm_to_fpga_cmd_valid, bus.arm_to_fpga_data_valid,
         bus.fpga_to_arm_data_ready, bus.fpga_to_arm_done_read} !== 8'b0 || bus.arm_to_fpga_cmd !== 32'd0
        || bus.arm_to_fpga_data !== 1024'd0) begin
      failures++;
      $display("FAIL midload_reset flags=%b want 00000000", {job_ready, res_valid, busy, err,
               bus.arm_to_fpga_cmd_valid, bus.arm_to_fpga_data_valid, bus.fpga_to_arm_data_ready,
               bus.fpga_to_arm_done_read});
    end
    resetn = 1'b1;
    step();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midload_idle job_ready=%b busy=%b want 1 0", job_ready, busy);
    end
    sl_min_delay = 0; sl_max_delay = 2;
  endtask

`ifdef RSA_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cb, wb, db, cyc, ex0, rv;
    bit tmo, seen;
    logic [1023:0] nn;
    ex0 = extra_done_reads;
    sl_never_done = 1'b1;
    start_job(rand1024(), rand1024(), rand1024(), rand1024(), rand1024(), cb, wb, db, tmo);
    seen = 1'b0; cyc = 0; rv = 0;
    while (cyc < 500) begin
      if (res_valid) rv++;
      if (bus.arm_to_fpga_cmd_valid && bus.arm_to_fpga_cmd == 32'd1) begin seen = 1'b1; break; end
      step(); cyc++;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL tmo_compute_seen got 0 want 1"); end
    repeat (16) begin step(); if (res_valid) rv++; end
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_early err=%b busy=%b want 0 1", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b1 || bus.fpga_to_arm_done_read !== 1'b1 || busy !== 1'b0 || job_ready !== 1'b1 || rv != 0
        || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fire err=%b done_read=%b busy=%b job_ready=%b res_valid_cycles=%0d want 1 1 0 1 0",
               err, bus.fpga_to_arm_done_read, busy, job_ready, rv);
    end
    step();
    checks++;
    if (bus.fpga_to_arm_done_read !== 1'b0 || err !== 1'b1 || extra_done_reads - ex0 !== 1) begin
      failures++;
      $display("FAIL tmo_after done_read=%b err=%b extra=%0d want 0 1 1", bus.fpga_to_arm_done_read, err,
               extra_done_reads - ex0);
    end
    sl_never_done = 1'b0;
    sl_clear = 1'b1; step(); sl_clear = 1'b0; step();
    nn = 1024'd13;
    test_single_job("tmo_next", 1024'd7, 1024'd2, nn, 1024'd1, 1024'd1);
  endtask
`else
  task automatic test_err_tied();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_tied got %b want 0", err); end
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [1023:0] m, e, nn;
    test_reset();
    test_single_job("single", 1024'd5, 1024'd3, 1024'hD, 1024'd3, 1024'd9);
    sl_stale = 3;
    test_single_job("stale", 1024'd5, 1024'd3, 1024'hD, 1024'd3, 1024'd9);
    sl_stale = 0;
    test_backpressure();
    for (int j = 0; j < 4; j++) begin
      sl_max_delay = $urandom_range(4, 0);
      sl_stale = int'($urandom_range(2, 0));
      m = rand1024(); e = rand1024(); nn = rand1024(); nn[0] = 1'b1;
      test_single_job($sformatf("rand%0d", j), m, e, nn, rand1024(), rand1024());
    end
    sl_max_delay = 2; sl_stale = 0;
    test_reset_mid_load();
    test_single_job("after_reset", 1024'd11, 1024'd17, 1024'd101, 1024'd4, 1024'd16);
`ifdef RSA_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_cmd_master.md
# rsa_cmd_master

Host-side initiator for the RSA command/data interface: takes one exponentiation job (five 1024-bit operands) on a valid/ready port, drives the command, data and done handshakes that the RSA FPGA wrapper responds to, and returns the 1024-bit result on a second valid/ready port. It sits in place of the ARM software driver, for on-chip sequencing and self-checking benches. It connects port-for-port to the wrapper's `arm_to_fpga_*` / `fpga_to_arm_*` signals.

## Interface
- `TIMEOUT_CYCLES`, default 1048576: cycles allowed per done-wait (used only with `RSA_MASTER_TIMEOUT_EN`).
- `clk` in 1: single clock, all logic rising-edge.
- `resetn` in 1: synchronous, active-low reset.
- `job_valid` in 1 / `job_ready` out 1: job handshake.
- `job_msg`, `job_exp`, `job_n`, `job_rmodn`, `job_r2modn` in 1024 each: operands, sampled on job accept.
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out 1024: result handshake.
- `busy` out 1: job in flight.
- `err` out 1: timeout flag, sticky until next job accept.
- `arm_to_fpga_cmd` out 32 / `arm_to_fpga_cmd_valid` out 1: command to slave. Codes: LOAD=0, COMPUTE=1, READBACK=2.
- `arm_to_fpga_data` out 1024 / `arm_to_fpga_data_valid` out 1 / `arm_to_fpga_data_ready` in 1: operand word to slave.
- `fpga_to_arm_data` in 1024 / `fpga_to_arm_data_valid` in 1 / `fpga_to_arm_data_ready` out 1: result from slave.
- `fpga_to_arm_done` in 1 / `fpga_to_arm_done_read` out 1: per-command completion.

## Operation
- All outputs are registered. Reset value is 0 for every output except `job_ready`, which is 1 from the first cycle after reset.
- States:
  - IDLE
  - CMD
  - DATA_OUT
  - DATA_IN
  - WAIT_DONE
  - ACK
  - DRAIN
  - RESULT
- Phase register selects the next transaction:
  - LOAD0..LOAD5
  - COMPUTE
  - READBACK
- **IDLE:** `job_ready`=1. On `job_valid`:
  - latch the five operands;
  - clear `err`, set `busy`, set phase=LOAD0;
  - go to CMD.
- **CMD:** drive `arm_to_fpga_cmd` per phase with `cmd_valid`=1 for exactly one cycle.
  - LOAD goes to DATA_OUT.
  - COMPUTE goes to WAIT_DONE.
  - READBACK goes to DATA_IN.
- **DATA_OUT:** wait for `arm_to_fpga_data_ready`=1. Then drive `data_valid` for exactly one cycle with the word for the phase, then go to WAIT_DONE. Word order:
  - LOAD0: msg
  - LOAD1: exp
  - LOAD2: n
  - LOAD3: rmodn
  - LOAD4: r2modn
  - LOAD5: all-zero pad word. The pad keeps the slave's six-slot parameter counter aligned across jobs.
- **DATA_IN:** wait for `fpga_to_arm_data_valid`=1. Then capture `fpga_to_arm_data` into the result register, pulse `fpga_to_arm_data_ready` for one cycle, and go to WAIT_DONE.
- **WAIT_DONE:** wait for `fpga_to_arm_done`=1, then go to ACK.
- **ACK:** pulse `done_read` for one cycle, then go to DRAIN.
- **DRAIN:** wait until `fpga_to_arm_done`=0. The slave's done is registered and stays high at least one cycle after the ack; it must never be counted as the next done. Then advance the phase:
  - LOAD0..LOAD4 go to the next LOAD.
  - LOAD5 goes to COMPUTE.
  - COMPUTE goes to READBACK.
  - READBACK goes to RESULT.
  - For every phase except READBACK, return to CMD.
- **RESULT:** `res_valid`=1 and `res_data` stable until `res_ready`. Then clear `busy` and go to IDLE.
- A job is exactly 8 commands: 0,0,0,0,0,0,1,2.
- Simultaneous `job_valid` and in-flight job: not accepted (`job_ready`=0 outside IDLE).

## Timing
- Each handshake output changes one cycle after the input it responds to is sampled.
- `cmd_valid`, `data_valid`, `fpga_to_arm_data_ready` and `done_read` are single-cycle pulses, never held.
- Minimum DRAIN is 1 cycle.
- Job latency is slave-dependent and unbounded without the timeout.
- Reset mid-operation: next cycle every output returns to its reset value, state=IDLE, phase=LOAD0, operands unchanged. The slave shares `resetn` and is required to reset with it.

## Configuration
- `RSA_MASTER_TIMEOUT_EN` defined:
  - a 32-bit counter clears on entry to DATA_OUT, DATA_IN, WAIT_DONE and DRAIN;
  - it increments each cycle spent in those states;
  - on reaching `TIMEOUT_CYCLES` the block sets `err`, pulses `done_read` once, clears `busy`, and returns to IDLE without `res_valid`.
- `RSA_MASTER_TIMEOUT_EN` undefined: no counter; waits are unbounded; `err` is tied 0.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles -> all outputs 0; one cycle after release `job_ready`=1.
- **Single job vs. behavioural slave:** msg=5, exp=3, n=0xD, rmodn=3, r2modn=9; slave returns 5^3 mod 13 -> command sequence 0,0,0,0,0,0,1,2; data words 5,3,0xD,3,9,0; `res_data`=8; `busy` low after `res_ready`.
- **Stale done:** slave holds done 3 cycles after `done_read` -> exactly one `done_read` per command; next `cmd_valid` only after done=0; still 8 commands total.
- **Result backpressure:** `res_ready`=0 for 10 cycles -> `res_valid` stays 1, `res_data` unchanged, `job_ready`=0; accept on cycle 11, back in IDLE next cycle.
- **Timeout:** macro on, `TIMEOUT_CYCLES`=16, slave never raises done after COMPUTE -> `err`=1 after 16 WAIT_DONE cycles, no `res_valid`, `job_ready`=1; the next job clears `err`.
- **Reset mid-load:** `resetn`=0 during LOAD2 DATA_OUT -> next cycle all outputs 0, state IDLE; a fresh job then completes with correct 8-command order.
